// File: rtl/led_chaser_multi.sv
// LED pattern generator: bounce with end dwell, rotate left/right and fill bar,
// advancing once per prescaler tick.
module led_chaser_multi #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             step_pulse,
    output logic             end_hit
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [WIDTH-1:0] LED_START = WIDTH'(1);

    logic [WIDTH-1:0] led_q, led_d;
    dir_e             dir_q, dir_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    mode_e            mode_q, mode_d;
    logic             step_pulse_q, step_pulse_d;
    logic             end_hit_q, end_hit_d;

    logic tick;
    logic at_end;

    assign tick   = en && (cnt_q >= div);
    assign at_end = (dir_q == DIR_LEFT) ? led_q[WIDTH-1] : led_q[0];

    always_comb begin
        led_d        = led_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        dwell_d      = dwell_q;
        mode_d       = mode_q;
        step_pulse_d = 1'b0;
        end_hit_d    = 1'b0;

        if (mode_e'(mode) != mode_q) begin
            led_d   = LED_START;
            dir_d   = DIR_LEFT;
            cnt_d   = '0;
            dwell_d = '0;
            mode_d  = mode_e'(mode);
        end else if (tick) begin
            cnt_d        = '0;
            step_pulse_d = 1'b1;
            case (mode_q)
                MODE_BOUNCE: begin
                    // At an end: burn the dwell ticks first, then reverse and move away.
                    if (at_end) begin
                        if (int'(dwell_q) < DWELL) begin
                            dwell_d = dwell_q + 1'b1;
                        end else begin
                            dwell_d = '0;
                            if (dir_q == DIR_LEFT) begin
                                dir_d = DIR_RIGHT;
                                led_d = led_q >> 1;
                            end else begin
                                dir_d = DIR_LEFT;
                                led_d = led_q << 1;
                            end
                        end
                    end else if (dir_q == DIR_LEFT) begin
                        led_d     = led_q << 1;
                        end_hit_d = led_q[WIDTH-2];
                    end else begin
                        led_d     = led_q >> 1;
                        end_hit_d = led_q[1];
                    end
                end
                MODE_ROTL: begin
                    led_d     = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    end_hit_d = led_q[WIDTH-2];
                end
                MODE_ROTR: begin
                    led_d     = {led_q[0], led_q[WIDTH-1:1]};
                    end_hit_d = led_q[1];
                end
                MODE_FILL: begin
                    if (&led_q) begin
                        led_d = '0;
                    end else begin
                        led_d     = {led_q[WIDTH-2:0], 1'b1};
                        end_hit_d = (&led_q[WIDTH-2:0]) && !led_q[WIDTH-1];
                    end
                end
                default: led_d = LED_START;
            endcase
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= LED_START;
            dir_q        <= DIR_LEFT;
            cnt_q        <= '0;
            dwell_q      <= '0;
            mode_q       <= mode_e'(mode);
            step_pulse_q <= 1'b0;
            end_hit_q    <= 1'b0;
        end else begin
            led_q        <= led_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            mode_q       <= mode_d;
            step_pulse_q <= step_pulse_d;
            end_hit_q    <= end_hit_d;
        end
    end

    assign led        = led_q;
    assign step_pulse = step_pulse_q;
    assign end_hit    = end_hit_q;

endmodule

// File: tb/tb_led_chaser_multi.sv
// Bench for led_chaser_multi: two instances (DWELL=2 and DWELL=0) checked each
// cycle against a sequence-table model, plus directed literal expectations.
module tb_led_chaser_multi;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [23:0] div = '0;

    logic [W-1:0] led2, led0;
    logic         sp2, sp0, eh2, eh0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_chaser_multi #(.WIDTH(W), .DIV_W(24), .DWELL(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
        .led(led2), .step_pulse(sp2), .end_hit(eh2)
    );

    led_chaser_multi #(.WIDTH(W), .DIV_W(24), .DWELL(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
        .led(led0), .step_pulse(sp0), .end_hit(eh0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each mode is a fixed periodic sequence of LED values; a tick
    // advances an index into it.
    function automatic int seq_len(input int md, input int d);
        case (md)
            0:       return 2 * W - 1 + 2 * d;
            3:       return W + 1;
            default: return W;
        endcase
    endfunction

    function automatic int bounce_pos(input int d, input int i);
        if (i < W) return i;
        if (i < W + d) return W - 1;
        if (i < 2 * W - 1 + d) return 2 * W - 2 + d - i;
        return 0;
    endfunction

    function automatic logic [W-1:0] seq_led(input int md, input int d, input int i);
        case (md)
            0:       return W'(1) << bounce_pos(d, i);
            1:       return W'(1) << i;
            2:       return W'(1) << ((W - i) % W);
            default: return W'((32'd1 << i) - 1);
        endcase
    endfunction

    function automatic bit seq_end(input int md, input int d, input int i);
        case (md)
            0:       return (i == W - 1) || (i == 2 * W - 2 + d);
            1:       return i == W - 1;
            2:       return i == 0;
            default: return i == W;
        endcase
    endfunction

    function automatic int seq_start(input int md);
        return (md == 3) ? 1 : 0;
    endfunction

    function automatic int seq_next(input int md, input int d, input int i);
        if (i + 1 < seq_len(md, d)) return i + 1;
        return (md == 0) ? 1 : 0;
    endfunction

    bit m_valid = 1'b0;
    int m_mode[2];
    int m_idx[2];
    int m_cnt[2];
    bit m_step[2];
    bit m_end[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 0 : 2;
            if (reset || (m_valid && int'(mode) != m_mode[k])) begin
                m_mode[k] = int'(mode);
                m_idx[k]  = seq_start(int'(mode));
                m_cnt[k]  = 0;
                m_step[k] = 1'b0;
                m_end[k]  = 1'b0;
            end else if (en && m_cnt[k] >= int'(div)) begin
                m_cnt[k]  = 0;
                m_idx[k]  = seq_next(m_mode[k], d, m_idx[k]);
                m_step[k] = 1'b1;
                m_end[k]  = seq_end(m_mode[k], d, m_idx[k]);
            end else begin
                if (en) m_cnt[k] = m_cnt[k] + 1;
                m_step[k] = 1'b0;
                m_end[k]  = 1'b0;
            end
        end
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_led_d0", 32'(led0), 32'(seq_led(m_mode[0], 0, m_idx[0])));
            check("model_step_d0", 32'(sp0), 32'(m_step[0]));
            check("model_end_d0", 32'(eh0), 32'(m_end[0]));
            check("model_led_d2", 32'(led2), 32'(seq_led(m_mode[1], 2, m_idx[1])));
            check("model_step_d2", 32'(sp2), 32'(m_step[1]));
            check("model_end_d2", 32'(eh2), 32'(m_end[1]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Bounce, div=0
        step(1);
        check("reset_led0", 32'(led0), 32'h01);
        check("reset_led2", 32'(led2), 32'h01);
        check("reset_step", 32'(sp2), 32'h0);
        reset = 1'b0;
        step(7);
        check("b0_at_80", 32'(led0), 32'h80);
        check("b0_end_80", 32'(eh0), 32'h1);
        step(1);
        check("b0_back_40", 32'(led0), 32'h40);
        check("b2_dwell_80", 32'(led2), 32'h80);
        check("b2_dwell_step", 32'(sp2), 32'h1);
        check("b2_dwell_noend", 32'(eh2), 32'h0);
        step(2);
        check("b2_after_dwell", 32'(led2), 32'h40);
        step(4);
        check("b0_at_01", 32'(led0), 32'h01);
        check("b0_end_01", 32'(eh0), 32'h1);
        step(6);

        // Rotate left, div=3
        mode = 2'b01;
        div  = 24'd3;
        step(1);
        check("rotl_change_led", 32'(led2), 32'h01);
        check("rotl_change_step", 32'(sp2), 32'h0);
        step(4);
        check("rotl_first", 32'(led2), 32'h02);
        step(24);
        check("rotl_80", 32'(led2), 32'h80);
        check("rotl_80_end", 32'(eh2), 32'h1);
        step(4);
        check("rotl_wrap", 32'(led2), 32'h01);

        // Rotate right from reset
        mode  = 2'b10;
        div   = '0;
        reset = 1'b1;
        step(1);
        check("rotr_reset", 32'(led2), 32'h01);
        reset = 1'b0;
        step(1);
        check("rotr_80", 32'(led2), 32'h80);
        check("rotr_80_noend", 32'(eh2), 32'h0);
        step(1);
        check("rotr_40", 32'(led2), 32'h40);

        // Fill bar
        mode = 2'b11;
        step(1);
        check("fill_start", 32'(led2), 32'h01);
        step(7);
        check("fill_ff", 32'(led2), 32'hFF);
        check("fill_ff_end", 32'(eh2), 32'h1);
        step(1);
        check("fill_zero", 32'(led2), 32'h00);
        check("fill_zero_noend", 32'(eh2), 32'h0);
        step(1);
        check("fill_restart", 32'(led2), 32'h01);

        // Freeze with en=0, then div lowered below cnt
        mode = 2'b01;
        div  = 24'd3;
        step(1);
        step(2);
        en = 1'b0;
        step(10);
        check("frozen_led", 32'(led2), 32'h01);
        check("frozen_step", 32'(sp2), 32'h0);
        en = 1'b1;
        step(1);
        check("resume_hold", 32'(led2), 32'h01);
        step(1);
        check("resume_tick", 32'(led2), 32'h02);
        check("resume_step", 32'(sp2), 32'h1);
        div = 24'd10;
        step(5);
        div = 24'd2;
        step(1);
        check("div_lowered", 32'(led2), 32'h04);
        mode = 2'b00;
        step(1);
        check("midrun_change_led", 32'(led2), 32'h01);
        check("midrun_change_step", 32'(sp2), 32'h0);
        check("midrun_change_end", 32'(eh2), 32'h0);

        // Reset during dwell at 80
        div = '0;
        step(7);
        check("dwell_pre_80", 32'(led2), 32'h80);
        step(1);
        reset = 1'b1;
        step(1);
        check("dwell_reset_led", 32'(led2), 32'h01);
        check("dwell_reset_step", 32'(sp2), 32'h0);
        reset = 1'b0;
        step(1);
        check("dwell_reset_left", 32'(led2), 32'h02);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
